spi_master_cfg: RTL and testbench

Parametrised SPI master, next generation of the fixed 16-bit, mode-0 trigger SPI block in the collect/trgg path. Adds configurable word width, clock divider and setup/hold delays, selectable CPOL/CPHA per transfer, a real active-low chip select, and a latched transmit word. Keeps the existing fs/fd level handshake so it drops into the same controller FSMs.

---
 rtl/spi_master_cfg.sv | 167 ++++++++++++++++
 tb/tb_spi_master_cfg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// Parametrised SPI master with fs/fd level handshake, CPOL/CPHA per transfer, real cs_n.
// Optional internal loopback of mosi into the receive path when SPI_LOOPBACK_EN is defined.
module spi_master_cfg #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned HALF_DIV    = 10,
  parameter int unsigned SYNC_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loop,
`endif
  input  logic                  fs,
  output logic                  fd,
  output logic                  busy,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] txd,
  output logic [DATA_WIDTH-1:0] rxd,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi
);

  // One counter serves both the cs_n setup/hold windows and the per-bit phase.
  localparam int unsigned CntMax = (2 * HALF_DIV > SYNC_CYCLES) ? 2 * HALF_DIV - 1
                                                                 : SYNC_CYCLES - 1;
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;
  localparam int unsigned BitW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CntW-1:0] SyncLast = CntW'(SYNC_CYCLES - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_DIV - 1);
  localparam logic [CntW-1:0] HalfMark = CntW'(HALF_DIV);
  localparam logic [CntW-1:0] PhLast   = CntW'(2 * HALF_DIV - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StWait, StLead, StShift, StTrail, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rxd_q, rxd_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  sclk_q, sclk_d;
  logic                  rx_in;

`ifdef SPI_LOOPBACK_EN
  logic loop_q, loop_d;
  assign rx_in = loop_q ? tx_q[DATA_WIDTH-1] : miso;
`else
  assign rx_in = miso;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
`ifdef SPI_LOOPBACK_EN
    loop_d  = loop_q;
`endif
    unique case (state_q)
      StIdle: state_d = StWait;
      StWait: begin
        if (fs) begin
          state_d = StLead;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = txd;
          rx_d    = '0;
          cpol_d  = mode[1];
          cpha_d  = mode[0];
`ifdef SPI_LOOPBACK_EN
          loop_d  = loop;
`endif
        end
      end
      StLead: begin
        if (cnt_q == SyncLast) begin
          state_d = StShift;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        // Sample on the clk edge that moves sclk across the mid-bit point (both CPHA).
        if (cnt_q == HalfLast) rx_d = DATA_WIDTH'({rx_q, rx_in});
        if (cnt_q == PhLast) begin
          cnt_d = '0;
          if (bit_q == LastBit) begin
            state_d = StTrail;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = tx_q << 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTrail: begin
        if (cnt_q == SyncLast) begin
          state_d = StDone;
          cnt_d   = '0;
          rxd_d   = rx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: if (!fs) state_d = StWait;
      default: state_d = StIdle;
    endcase

    // sclk is registered from next-state so it switches on the same edge as cnt.
    case (state_d)
      StIdle, StWait: sclk_d = 1'b0;
      StShift:        sclk_d = cpol_d ^ ((cnt_d >= HalfMark) ^ cpha_d);
      default:        sclk_d = cpol_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      loop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
`ifdef SPI_LOOPBACK_EN
      loop_q  <= loop_d;
`endif
    end
  end

  assign busy = (state_q == StLead) || (state_q == StShift) || (state_q == StTrail);
  assign cs_n = ~busy;
  assign fd   = (state_q == StDone);
  assign mosi = busy & tx_q[DATA_WIDTH-1];
  assign rxd  = rxd_q;
  // Before a transfer is latched the idle level follows the live CPOL request.
  assign sclk = (state_q == StWait) ? mode[1] : sclk_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: a protocol-level SPI slave model drives miso and captures mosi,
// two instances (default and small parameters) are exercised through a shared pin mux.
module tb_spi_master_cfg;

  localparam int DW  = 16, HD  = 10, SC  = 16;
  localparam int SDW = 8,  SHD = 2,  SSC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] txd = '0;
  logic        miso = 1'b0;
  logic        loop = 1'b0;

  always #5 clk = ~clk;

  logic        m_fs, m_fd, m_busy, m_cs_n, m_sclk, m_mosi;
  logic [15:0] m_rxd;
  logic        s_fs, s_fd, s_busy, s_cs_n, s_sclk, s_mosi;
  logic [7:0]  s_rxd;
  logic        p_fd, p_busy, p_cs_n, p_sclk, p_mosi;
  logic [15:0] p_rxd;

  assign m_fs   = fs & ~sel;
  assign s_fs   = fs & sel;
  assign p_fd   = sel ? s_fd   : m_fd;
  assign p_busy = sel ? s_busy : m_busy;
  assign p_cs_n = sel ? s_cs_n : m_cs_n;
  assign p_sclk = sel ? s_sclk : m_sclk;
  assign p_mosi = sel ? s_mosi : m_mosi;
  assign p_rxd  = sel ? {8'h00, s_rxd} : m_rxd;

  spi_master_cfg #(.DATA_WIDTH(DW), .HALF_DIV(HD), .SYNC_CYCLES(SC)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef SPI_LOOPBACK_EN
    .loop (loop),
`endif
    .fs   (m_fs),
    .fd   (m_fd),
    .busy (m_busy),
    .mode (mode),
    .txd  (txd),
    .rxd  (m_rxd),
    .miso (miso),
    .cs_n (m_cs_n),
    .sclk (m_sclk),
    .mosi (m_mosi)
  );

  spi_master_cfg #(.DATA_WIDTH(SDW), .HALF_DIV(SHD), .SYNC_CYCLES(SSC)) u_small (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef SPI_LOOPBACK_EN
    .loop (1'b0),
`endif
    .fs   (s_fs),
    .fd   (s_fd),
    .busy (s_busy),
    .mode (mode),
    .txd  (txd[7:0]),
    .rxd  (s_rxd),
    .miso (miso),
    .cs_n (s_cs_n),
    .sclk (s_sclk),
    .mosi (s_mosi)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    fs    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_n", m_cs_n, 1'b1);
    check("rst_sclk", m_sclk, 1'b0);
    check("rst_mosi", m_mosi, 1'b0);
    check("rst_fd",   m_fd,   1'b0);
    check("rst_busy", m_busy, 1'b0);
    check("rst_rxd",  m_rxd,  16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full transfer on the selected instance; the slave model follows CPOL/CPHA rules.
  task automatic xfer(input logic [1:0] m, input logic [15:0] tx, input logic [15:0] sw,
                      input int hold, input logic corrupt, input logic lp);
    int          dw, hd, sc, n, cs_low, leads, sidx, fdh;
    logic        cpol, cpha, prev_sclk, prev_cs, lead_edge;
    logic [15:0] got, mask, rx_exp;
    dw = sel ? SDW : DW;
    hd = sel ? SHD : HD;
    sc = sel ? SSC : SC;
    mask = 16'hFFFF >> (16 - dw);
    cpol = m[1];
    cpha = m[0];
    mode = m;
    txd  = tx;
    loop = lp;
    #1;
    check("wait_sclk_tracks_cpol", p_sclk, cpol);
    fs = 1'b1;
    n = 0; cs_low = 0; leads = 0; sidx = dw - 1; got = '0; fdh = 0;
    prev_sclk = cpol;
    prev_cs   = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!p_cs_n) begin
        cs_low++;
        if (prev_cs && !cpha) begin
          if (sidx >= 0) miso = sw[sidx];
          sidx--;
        end
        if (p_sclk != prev_sclk) begin
          lead_edge = (p_sclk != cpol);
          if (lead_edge) leads++;
          if (lead_edge != cpha) begin
            got = {got[14:0], p_mosi};
          end else if (lead_edge || prev_sclk != cpol) begin
            if (sidx >= 0) miso = sw[sidx];
            sidx--;
          end
        end
        prev_sclk = p_sclk;
      end
      prev_cs = p_cs_n;
      if (corrupt && n == 1) begin
        txd  = ~tx;
        mode = ~m;
      end
    end while (!p_fd && n < 5000);
    rx_exp = lp ? tx : sw;
    check("latency",     n,            2 * sc + dw * 2 * hd + 1);
    check("cs_low",      cs_low,       2 * sc + dw * 2 * hd);
    check("pulses",      leads,        dw);
    check("mosi_word",   got & mask,   tx & mask);
    check("rxd",         p_rxd,        rx_exp & mask);
    check("done_sclk",   p_sclk,       cpol);
    check("done_cs_n",   p_cs_n,       1'b1);
    check("done_busy",   p_busy,       1'b0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (p_fd) fdh++;
    end
    check("fd_hold", fdh, hold);
    fs = 1'b0;
    @(posedge clk);
    #1;
    check("fd_clear", p_fd, 1'b0);
    check("rxd_hold", p_rxd, rx_exp & mask);
    miso = 1'b0;
  endtask

  task automatic reset_mid();
    int n;
    mode = 2'b01;
    txd  = 16'($urandom);
    fs   = 1'b1;
    n    = 0;
    // Land inside bit 7 of the shift window.
    while (n < 1 + SC + 7 * 2 * HD + 5) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mid_busy_before", m_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_cs_n", m_cs_n, 1'b1);
    check("mid_sclk", m_sclk, 1'b0);
    check("mid_fd",   m_fd,   1'b0);
    check("mid_rxd",  m_rxd,  16'h0);
    check("mid_mosi", m_mosi, 1'b0);
    apply_reset();
  endtask

  initial begin
    apply_reset();
    sel = 1'b0;
    xfer(2'b00, 16'hA55A, 16'h3C96, 0, 1'b0, 1'b0);
    xfer(2'($urandom_range(3)), 16'($urandom), 16'($urandom), 10, 1'b0, 1'b0);
    xfer(2'($urandom_range(3)), 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
    xfer(2'b10, 16'hFFFF, 16'($urandom), 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer(2'($urandom_range(3)), 16'($urandom), 16'($urandom), int'($urandom_range(3)),
           1'b0, 1'b0);
    end
    xfer(2'b01, 16'h8001, 16'h7FFE, 0, 1'b0, 1'b0);
    reset_mid();
    xfer(2'b01, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
`ifdef SPI_LOOPBACK_EN
    xfer(2'b10, 16'h1234, 16'h0000, 0, 1'b0, 1'b1);
    loop = 1'b0;
`endif
    sel = 1'b1;
    xfer(2'b11, 16'h00C3, 16'h005E, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer(2'($urandom_range(3)), 16'($urandom), 16'($urandom), 2, 1'b0, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
